// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax arithmetic blocks.
package softmax_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} div_state_t;

  // Saturation limits for a dw-bit two's-complement quotient, truncated by the caller.
  function automatic logic [63:0] q_max(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] q_min(input int unsigned dw);
    return 64'd1 << (dw - 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {1'b0, divisor};
    // The partial remainder never reaches 2^W, so diff[W] is a true borrow.
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 signed divider, one quotient bit per cycle, start/busy/done handshake.
module div_seq
  import softmax_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned VW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a_in,
  input  logic [VW-1:0] b_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q_out,
  output logic [VW-1:0] r_out,
  output logic          dbz,
  output logic          ovf
);

  localparam int unsigned   CW    = cnt_width(DW);
  localparam int unsigned   RW    = VW + 1;
  localparam logic [DW-1:0] QMax  = DW'(q_max(DW));
  localparam logic [DW-1:0] QMin  = DW'(q_min(DW));
  localparam logic [CW-1:0] Last  = CW'(DW - 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] bmag_q, bmag_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] a_q, a_d;
  logic [VW-1:0] b_q, b_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [RW-1:0] rem_next;
  logic          q_bit;
  logic [DW-1:0] q_mag;
  logic [VW-1:0] r_mag;

  div_step #(.W(RW)) u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[DW-1]),
    .divisor  (bmag_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Dividend bits shift out the top while quotient bits fill in from the bottom.
  assign q_mag = {dvd_q[DW-2:0], q_bit};
  assign r_mag = rem_next[VW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    dvd_d   = dvd_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCalc;
          cnt_d   = '0;
          rem_d   = '0;
          a_d     = a_in;
          b_d     = b_in;
          dvd_d   = a_in[DW-1] ? (~a_in + 1'b1) : a_in;
          bmag_d  = {1'b0, (b_in[VW-1] ? (~b_in + 1'b1) : b_in)};
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        rem_d = rem_next;
        dvd_d = q_mag;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == Last) begin
          state_d = StDone;
          cnt_d   = '0;
          if (b_q == '0) begin
            dbz_d = 1'b1;
            ovf_d = 1'b0;
            q_d   = a_q[DW-1] ? QMin : QMax;
            r_d   = a_q[VW-1:0];
          end else if (a_q == QMin && b_q == '1) begin
            dbz_d = 1'b0;
            ovf_d = 1'b1;
            q_d   = QMax;
            r_d   = '0;
          end else begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            q_d   = (a_q[DW-1] ^ b_q[VW-1]) ? (~q_mag + 1'b1) : q_mag;
            r_d   = a_q[DW-1] ? (~r_mag + 1'b1) : r_mag;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      dvd_q   <= dvd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == StCalc);
  assign done  = (state_q == StDone);
  assign q_out = q_q;
  assign r_out = r_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector and randomised identity bench for div_seq (DW = VW = 32).
module tb_div_seq;

  localparam int DW = 32;
  localparam int VW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a_in;
  logic [VW-1:0] b_in;
  logic          busy;
  logic          done;
  logic [DW-1:0] q_out;
  logic [VW-1:0] r_out;
  logic          dbz;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .q_out (q_out),
    .r_out (r_out),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Cycle k is the k-th cycle after the start edge; done is expected at k = DW+1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                        input bit chk_hold, input logic [31:0] hold_q,
                        output int done_k, output int busy_n);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    done_k = 0;
    busy_n = 0;
    for (int k = 1; k <= DW + 8; k++) begin
      @(negedge clk);
      start = (k == pulse_at);
      if (k == pulse_at) begin
        a_in = 32'd9;
        b_in = 32'd2;
      end
      if (chk_hold && k == 3) chk("hold_in_calc", q_out, hold_q);
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, "_q"}, q_out, v.q);
    chk({nm, "_r"}, r_out, v.r);
    chk({nm, "_dbz"}, dbz, v.dbz);
    chk({nm, "_ovf"}, ovf, v.ovf);
  endtask

  initial begin
    int          dk;
    int          bn;
    int          nd;
    logic [31:0] prev_q;
    vec_t        v;

    tv[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
    tv[1]  = '{-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0};
    tv[2]  = '{32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b0};
    tv[3]  = '{-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 1'b0};
    tv[4]  = '{32'd5, 32'd0, 32'h7FFF_FFFF, 32'd5, 1'b1, 1'b0};
    tv[5]  = '{-32'sd5, 32'd0, 32'h8000_0000, -32'sd5, 1'b1, 1'b0};
    tv[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1};
    tv[7]  = '{32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0};
    tv[8]  = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0};
    tv[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 1'b0, 1'b0};
    // MIN = (-1) * MAX + (-1)
    tv[10] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", q_out, 32'd0);
    chk("rst_r", r_out, 32'd0);
    chk("rst_dbz", dbz, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    prev_q = 32'd0;
    for (int i = 0; i < 11; i++) begin
      run_op(tv[i].a, tv[i].b, 0, 1'b1, prev_q, dk, bn);
      chk($sformatf("v%0d_done_cycle", i), dk, DW + 1);
      chk($sformatf("v%0d_busy_cycles", i), bn, DW);
      chk_result($sformatf("v%0d", i), tv[i]);
      prev_q = tv[i].q;
    end

    // Results hold while idle.
    repeat (3) @(negedge clk);
    chk("idle_hold_q", q_out, prev_q);
    chk("idle_hold_r", r_out, tv[10].r);

    // A start pulse during CALC with other operands is ignored.
    run_op(32'd100, 32'd7, 5, 1'b1, prev_q, dk, bn);
    chk("midpulse_done_cycle", dk, DW + 1);
    chk_result("midpulse", tv[0]);

    // Back-to-back: start held through DONE starts the second op with no idle gap.
    @(negedge clk);
    a_in  = 32'd100;
    b_in  = 32'd7;
    start = 1'b1;
    @(posedge clk);
    dk = 0;
    for (int k = 1; k <= DW + 8; k++) begin
      @(negedge clk);
      a_in = -32'sd100;
      if (done) begin
        dk = k;
        break;
      end
    end
    chk("b2b_first_done", dk, DW + 1);
    chk_result("b2b_first", tv[0]);
    @(posedge clk);
    dk = 0;
    for (int k = 1; k <= DW + 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) chk("b2b_no_gap", busy, 1'b1);
      if (done) begin
        dk = k;
        break;
      end
    end
    chk("b2b_second_done", dk, DW + 1);
    chk_result("b2b_second", tv[1]);

    // Reset during CALC aborts without a done pulse.
    @(negedge clk);
    a_in  = 32'd100000;
    b_in  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", q_out, 32'd0);
    chk("abort_r", r_out, 32'd0);
    chk("abort_dbz", dbz, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    nd = 0;
    for (int k = 0; k < DW + 8; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(32'd1234567, 32'd89, 0, 1'b1, 32'd0, dk, bn);
    chk("post_abort_done_cycle", dk, DW + 1);
    v = '{32'd1234567, 32'd89, 32'd13871, 32'd48, 1'b0, 1'b0};
    chk_result("post_abort", v);

    // Random pairs: check the division identity and remainder bounds.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      longint      la, lb, lq, lr, abs_r, abs_b;
      ra = $urandom;
      rb = $urandom;
      rb = $signed(rb) >>> $urandom_range(0, 31);
      if (i % 8 == 0) ra = 32'h8000_0000;
      if (i % 8 == 1) ra = 32'h7FFF_FFFF;
      if (i % 8 == 2) rb = 32'h8000_0000;
      if (i % 8 == 3) rb = 32'h7FFF_FFFF;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      run_op(ra, rb, 0, 1'b0, 32'd0, dk, bn);
      la = longint'($signed(ra));
      lb = longint'($signed(rb));
      lq = longint'($signed(q_out));
      lr = longint'($signed(r_out));
      abs_r = (lr < 0) ? -lr : lr;
      abs_b = (lb < 0) ? -lb : lb;
      chk($sformatf("rand%0d_identity", i), lq * lb + lr, la);
      chk($sformatf("rand%0d_rmag", i), abs_r < abs_b, 1'b1);
      if (lr != 0) chk($sformatf("rand%0d_rsign", i), lr < 0, la < 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential radix-2 signed integer divider with a start/busy/done handshake, identical in contract to the softmax multiplier.
- Performs the softmax normalisation divide: exp(x_i) / sum(exp).
- Computes one quotient bit per cycle.
- Results are held stable until the next accepted start.

Parameters:
- DW, 32: dividend and quotient width (signed).
- VW, 32: divisor and remainder width (signed); VW <= DW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a_in  in  DW  signed dividend; sampled with start.
- b_in  in  VW  signed divisor; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when results are valid.
- q_out  out  DW  signed quotient.
- r_out  out  VW  signed remainder.
- dbz  out  1  divide-by-zero flag, valid with done and held.
- ovf  out  1  overflow flag (MIN / -1), valid with done and held.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, q_out=0, r_out=0, dbz=0, ovf=0; iteration counter=0.
- Reset asserted mid-operation aborts the operation at that edge. No done is issued for the aborted operation.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE→CALC: on start=1. Latch a_in and b_in, record the operand signs, load |a| and |b|, counter=0.
  - CALC→CALC: each cycle performs one restoring step. Shift the partial remainder left, bringing in the next dividend MSB. Trial-subtract |b|; if the result is non-negative, keep it and set the quotient bit to 1, else restore. Counter increments.
  - CALC→DONE: after DW steps (counter reaches DW-1). The sign-corrected q_out, r_out, dbz and ovf are registered on this edge.
  - DONE→IDLE: when start=0.
  - DONE→CALC: when start=1 (back-to-back accept).
- Latency: start sampled at edge t. busy is high for cycles t+1 .. t+DW. done is high for cycle t+DW+1 only. This latency is fixed, including the dbz and ovf cases.
- start while busy=1 is ignored. a_in and b_in changes during CALC have no effect.
- Arithmetic: truncation toward zero.
  - q sign = sign(a) XOR sign(b).
  - r sign = sign(a); |r| < |b|.
  - a = q*b + r holds exactly whenever dbz=0 and ovf=0.
  - Magnitudes use DW+1 bits internally so that |MIN| is representable.
- Divide by zero (b=0):
  - dbz=1.
  - q_out = +MAX (2^(DW-1)-1) if a >= 0, else MIN (-2^(DW-1)).
  - r_out = a truncated to VW bits.
  - ovf=0.
- Overflow (a = MIN, b = -1):
  - ovf=1, q_out=+MAX, r_out=0, dbz=0.
- Output holding: q_out, r_out, dbz and ovf hold from DONE until the next DONE. They do not change during CALC.

Decomposition:
- Shared package softmax_pkg holds:
  - state encoding div_state_t {IDLE, CALC, DONE};
  - constants Q_MAX and Q_MIN as functions of DW;
  - counter width as $clog2(DW).
- Sub-module div_step (combinational): one restoring shift/subtract iteration.
  - Inputs: partial remainder, next dividend bit, |b|.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, the operand registers, and sign correction.

Test Plan:
- 100 / 7 → q=14, r=2, dbz=0, ovf=0. done arrives exactly DW+1 cycles after the start edge; busy is high for exactly DW cycles.
- Sign cases on one bench, with results held until the next start:
  - -100 / 7 → q=-14, r=-2.
  - 100 / -7 → q=-14, r=2.
  - -100 / -7 → q=14, r=-2.
- Boundary operands:
  - 5 / 0 → dbz=1, q=0x7FFFFFFF, r=5.
  - -5 / 0 → dbz=1, q=0x80000000.
  - 0x80000000 / -1 → ovf=1, q=0x7FFFFFFF, r=0.
  - 0 / 3 → q=0, r=0.
- Handshake:
  - start pulsed again mid-CALC with different operands → ignored; the first result is returned.
  - start held high through the DONE cycle → second operation begins with no IDLE gap; its done arrives DW+1 cycles after that edge.
- Reset: rst asserted during CALC (step 10) → next cycle busy=0, done=0, outputs=0. No done pulse follows. A fresh 1234567 / 89 afterwards → q=13871, r=48.
- Randomised: 1000 random signed pairs, including MIN/MAX extremes → q*b + r == a, |r| < |b|, sign(r) = sign(a) whenever r != 0.
